// File: rtl/dom_slot_buffer_pkg.sv
// dom_pkg: shared types for the two-domain slot buffer.
//   dom_t    - 1-bit domain selector, DOM_D1 = 0, DOM_D2 = 1.
//   state_t  - slot schedule states.
//   state_dom() - domain presented on out_dom for a given schedule state.
package dom_pkg;

    typedef enum logic {
        DOM_D1 = 1'b0,
        DOM_D2 = 1'b1
    } dom_t;

    typedef enum logic [1:0] {
        ST_SLOT_D1  = 2'd0,
        ST_FLUSH_12 = 2'd1,
        ST_SLOT_D2  = 2'd2,
        ST_FLUSH_21 = 2'd3
    } state_t;

    // The flush cycle already belongs to the domain whose slot follows it.
    function automatic dom_t state_dom(input state_t s);
        if (s == ST_SLOT_D2 || s == ST_FLUSH_12) begin
            return DOM_D2;
        end
        return DOM_D1;
    endfunction

endpackage

// File: rtl/dom_slot_buffer_fifo.sv
// dom_fifo: single-domain circular FIFO used once per domain.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (empties the FIFO)
//   push, din   - write request and data; ignored while full
//   pop, dout   - read request and head data; pop ignored while empty
//   full, empty - status derived from the registered occupancy
//   count       - registered occupancy, 0..DEPTH
module dom_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == LP_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Full is taken from the registered count, so a same-cycle pop never
    // opens room for a push.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/dom_slot_buffer.sv
// dom_slot_buffer: two-domain (D1/D2) input buffering with a fixed,
// data-independent time-slot schedule on a single tagged output channel.
// Schedule: SLOT_D1 (SLOT_CYCLES) -> FLUSH_12 (1) -> SLOT_D2 (SLOT_CYCLES)
//           -> FLUSH_21 (1) -> ...; output is idle during flush cycles.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   d1_valid/data/ready - D1 write channel (ready = D1 FIFO not full)
//   d2_valid/data/ready - D2 write channel (ready = D2 FIFO not full)
//   out_dom             - registered active domain, 0 = D1, 1 = D2
//   out_valid/data      - head of the active domain's FIFO, zero when idle
//   out_ready           - consumer accept, honoured only in the matching slot
//   d1_count, d2_count  - registered occupancy, present only with DOM_OCC_EN
// Build option: define DOM_OCC_EN to expose the occupancy outputs.
module dom_slot_buffer
    import dom_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 4,
    parameter int SLOT_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d1_valid,
    input  logic [WIDTH-1:0]       d1_data,
    output logic                   d1_ready,
    input  logic                   d2_valid,
    input  logic [WIDTH-1:0]       d2_data,
    output logic                   d2_ready,
    output logic                   out_dom,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready
`ifdef DOM_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] d1_count,
    output logic [$clog2(DEPTH):0] d2_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned LAST_I = SLOT_CYCLES - 1;
    localparam logic [CW-1:0] LP_LAST = LAST_I[CW-1:0];

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_slot_cnt;
    logic [CW-1:0]  w_slot_cnt_nxt;
    dom_t           r_dom;
    logic           w_slot_active;

    logic             w_d1_full;
    logic             w_d1_empty;
    logic [WIDTH-1:0] w_d1_head;
    logic [AW:0]      w_d1_count;
    logic             w_d1_pop;

    logic             w_d2_full;
    logic             w_d2_empty;
    logic [WIDTH-1:0] w_d2_head;
    logic [AW:0]      w_d2_count;
    logic             w_d2_pop;

    // ---------------- schedule (label L: reset and cycle count only) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_SLOT_D1;
            r_slot_cnt <= '0;
            r_dom      <= DOM_D1;
        end else begin
            r_state    <= w_state_nxt;
            r_slot_cnt <= w_slot_cnt_nxt;
            r_dom      <= state_dom(w_state_nxt);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_slot_cnt_nxt = r_slot_cnt + 1'b1;
        case (r_state)
            ST_SLOT_D1: begin
                if (r_slot_cnt == LP_LAST) begin
                    w_state_nxt    = ST_FLUSH_12;
                    w_slot_cnt_nxt = '0;
                end
            end
            ST_FLUSH_12: begin
                w_state_nxt    = ST_SLOT_D2;
                w_slot_cnt_nxt = '0;
            end
            ST_SLOT_D2: begin
                if (r_slot_cnt == LP_LAST) begin
                    w_state_nxt    = ST_FLUSH_21;
                    w_slot_cnt_nxt = '0;
                end
            end
            ST_FLUSH_21: begin
                w_state_nxt    = ST_SLOT_D1;
                w_slot_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = ST_SLOT_D1;
                w_slot_cnt_nxt = '0;
            end
        endcase
    end

    assign w_slot_active = (r_state == ST_SLOT_D1) || (r_state == ST_SLOT_D2);
    assign out_dom       = r_dom;

    // ---------------- per-domain FIFOs ----------------------------------
    // Each pop uses only its own FIFO status plus the schedule state.
    assign w_d1_pop = (r_state == ST_SLOT_D1) && !w_d1_empty && out_ready;
    assign w_d2_pop = (r_state == ST_SLOT_D2) && !w_d2_empty && out_ready;

    dom_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_d1 (
        .clk   (clk),
        .reset (reset),
        .push  (d1_valid),
        .din   (d1_data),
        .pop   (w_d1_pop),
        .dout  (w_d1_head),
        .full  (w_d1_full),
        .empty (w_d1_empty),
        .count (w_d1_count)
    );

    dom_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_d2 (
        .clk   (clk),
        .reset (reset),
        .push  (d2_valid),
        .din   (d2_data),
        .pop   (w_d2_pop),
        .dout  (w_d2_head),
        .full  (w_d2_full),
        .empty (w_d2_empty),
        .count (w_d2_count)
    );

    assign d1_ready = !w_d1_full;
    assign d2_ready = !w_d2_full;

    // ---------------- output mux (selected by out_dom only) ------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (w_slot_active) begin
            if (r_dom == DOM_D1) begin
                out_valid = !w_d1_empty;
                out_data  = w_d1_empty ? '0 : w_d1_head;
            end else begin
                out_valid = !w_d2_empty;
                out_data  = w_d2_empty ? '0 : w_d2_head;
            end
        end
    end

`ifdef DOM_OCC_EN
    assign d1_count = w_d1_count;
    assign d2_count = w_d2_count;
`else
    logic w_unused_count;
    assign w_unused_count = ^{w_d1_count, w_d2_count};
`endif

endmodule

// File: tb/tb_dom_slot_buffer.sv
module tb_dom_slot_buffer;

    localparam int WIDTH       = 2;
    localparam int DEPTH       = 4;
    localparam int SLOT_CYCLES = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             d1_valid;
    logic [WIDTH-1:0] d1_data;
    logic             d1_ready;
    logic             d2_valid;
    logic [WIDTH-1:0] d2_data;
    logic             d2_ready;
    logic             out_dom;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef DOM_OCC_EN
    logic [2:0]       d1_count;
    logic [2:0]       d2_count;
`endif

    dom_slot_buffer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d1_valid  (d1_valid),
        .d1_data   (d1_data),
        .d1_ready  (d1_ready),
        .d2_valid  (d2_valid),
        .d2_data   (d2_data),
        .d2_ready  (d2_ready),
        .out_dom   (out_dom),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DOM_OCC_EN
        ,
        .d1_count  (d1_count),
        .d2_count  (d2_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             dom;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 of a fresh schedule.
    task automatic do_reset();
        reset     = 1'b1;
        d1_valid  = 1'b0;
        d1_data   = '0;
        d2_valid  = 1'b0;
        d2_data   = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Monitor: every accepted output word is checked against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got dom %0d data %0h, expected no word at %0t",
                             out_dom, out_data, $time);
                end else begin
                    e = q.pop_front();
                    chk("sb_dom", {31'd0, out_dom}, {31'd0, e.dom});
                    chk("sb_data", {30'd0, out_data}, {30'd0, e.data});
                end
            end
            if (!out_valid) begin
                chk("idle_data_zero", {30'd0, out_data}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin : main
        // ---- reset values ----
        reset     = 1'b1;
        d1_valid  = 1'b0;
        d1_data   = '0;
        d2_valid  = 1'b0;
        d2_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {30'd0, out_data}, 32'd0);
        chk("rst_dom", {31'd0, out_dom}, 32'd0);
        chk("rst_d1_ready", {31'd0, d1_ready}, 32'd1);
        chk("rst_d2_ready", {31'd0, d2_ready}, 32'd1);
        cyc();
        cyc();
        reset = 1'b0;

        // ---- schedule with no traffic ----
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("sched_dom", {31'd0, out_dom}, (k >= 8 && k <= 16) ? 32'd1 : 32'd0);
            chk("sched_valid", {31'd0, out_valid}, 32'd0);
            cyc();
        end

        // ---- isolation: D2 words pushed during D1 slot ----
        do_reset();
        d2_valid  = 1'b1;
        d2_data   = 2'b11;
        out_ready = 1'b1;
        q.push_back('{dom: 1'b1, data: 2'b11});
        cyc();
        d2_data = 2'b10;
        q.push_back('{dom: 1'b1, data: 2'b10});
        cyc();
        d2_valid = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 7) chk("iso_d1_slot_idle", {31'd0, out_valid}, 32'd0);
            if (k == 9) begin
                chk("iso_first_valid", {31'd0, out_valid}, 32'd1);
                chk("iso_first_data", {30'd0, out_data}, 32'd3);
            end
            if (k == 10) chk("iso_second_data", {30'd0, out_data}, 32'd2);
            if (k == 11) chk("iso_d2_drained", {31'd0, out_valid}, 32'd0);
            if (k == 18) chk("iso_d1_untouched", {31'd0, out_valid}, 32'd0);
            cyc();
        end
        chk("iso_sb_empty", q.size(), 32'd0);

        // ---- full boundary ----
        do_reset();
        d1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d1_data = 2'(k);
            if (k < 4) q.push_back('{dom: 1'b0, data: 2'(k)});
            @(negedge clk);
            chk("full_ready", {31'd0, d1_ready}, (k < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        d1_valid = 1'b0;
        for (int k = 5; k <= 22; k++) begin
            if (k == 18) out_ready = 1'b1;
            @(negedge clk);
            if (k == 17) chk("full_still_full", {31'd0, d1_ready}, 32'd0);
            if (k == 18) chk("full_head", {30'd0, out_data}, 32'd0);
            if (k == 21) chk("full_last", {30'd0, out_data}, 32'd3);
            if (k == 22) begin
                chk("full_drained_valid", {31'd0, out_valid}, 32'd0);
                chk("full_drained_ready", {31'd0, d1_ready}, 32'd1);
            end
            cyc();
        end
        chk("full_sb_empty", q.size(), 32'd0);

        // ---- flush and backpressure ----
        do_reset();
        d1_valid = 1'b1;
        d1_data  = 2'b01;
        q.push_back('{dom: 1'b0, data: 2'b01});
        cyc();
        d1_data = 2'b10;
        q.push_back('{dom: 1'b0, data: 2'b10});
        cyc();
        d1_valid = 1'b0;
        for (int k = 2; k <= 19; k++) begin
            if (k == 7) out_ready = 1'b1;
            @(negedge clk);
            if (k == 6) begin
                chk("fb_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("fb_hold_data", {30'd0, out_data}, 32'd1);
            end
            if (k == 8) begin
                chk("fb_flush_valid", {31'd0, out_valid}, 32'd0);
                chk("fb_flush_data", {30'd0, out_data}, 32'd0);
                chk("fb_flush_dom", {31'd0, out_dom}, 32'd1);
            end
            if (k == 12 || k == 17) chk("fb_d2_side_idle", {31'd0, out_valid}, 32'd0);
            if (k == 18) begin
                chk("fb_resume_valid", {31'd0, out_valid}, 32'd1);
                chk("fb_resume_data", {30'd0, out_data}, 32'd2);
            end
            if (k == 19) chk("fb_done_valid", {31'd0, out_valid}, 32'd0);
            cyc();
        end
        chk("fb_sb_empty", q.size(), 32'd0);

        // ---- concurrent push and pop at occupancy 2 ----
        do_reset();
        d1_valid = 1'b1;
        d1_data  = 2'b11;
        q.push_back('{dom: 1'b0, data: 2'b11});
        cyc();
        d1_data = 2'b01;
        q.push_back('{dom: 1'b0, data: 2'b01});
        cyc();
        d1_data   = 2'b10;
        q.push_back('{dom: 1'b0, data: 2'b10});
        out_ready = 1'b1;
        @(negedge clk);
        chk("cc_pop_data", {30'd0, out_data}, 32'd3);
        cyc();
        d1_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
`ifdef DOM_OCC_EN
        chk("cc_count", {29'd0, d1_count}, 32'd2);
`endif
        chk("cc_head", {30'd0, out_data}, 32'd1);
        chk("cc_ready", {31'd0, d1_ready}, 32'd1);
        cyc();
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) chk("cc_third", {30'd0, out_data}, 32'd2);
            if (k == 6) chk("cc_drained", {31'd0, out_valid}, 32'd0);
            cyc();
        end
        chk("cc_sb_empty", q.size(), 32'd0);

        // ---- reset mid-run discards buffered data ----
        do_reset();
        d2_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d1_valid = (k < 3);
            d1_data  = 2'(k);
            d2_data  = 2'(3 - k);
            cyc();
        end
        d1_valid = 1'b0;
        d2_valid = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        chk("mid_pre_dom", {31'd0, out_dom}, 32'd1);
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_pre_d2_ready", {31'd0, d2_ready}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_async_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_async_data", {30'd0, out_data}, 32'd0);
        chk("mid_async_dom", {31'd0, out_dom}, 32'd0);
        chk("mid_async_d1_ready", {31'd0, d1_ready}, 32'd1);
        chk("mid_async_d2_ready", {31'd0, d2_ready}, 32'd1);
        cyc();
        cyc();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("mid_post_no_old", {31'd0, out_valid}, 32'd0);
            if (k == 7) chk("mid_post_dom_c7", {31'd0, out_dom}, 32'd0);
            if (k == 8) chk("mid_post_dom_c8", {31'd0, out_dom}, 32'd1);
            cyc();
        end

        chk("sb_final_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
